uart_tx_ctrl: RTL

Memory-mapped UART transmitter driven by the core's store path. Stores with uart_select asserted push their low data byte into a small FIFO, and the block serialises each byte as an 8N1 frame on the tx pin. The fifo_full output is the pipeline's stall request: the core must hold the store while it is high.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_fifo.sv | 57 +++++
 rtl/uart_tx_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int FRAME_BITS           = 10;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small byte FIFO feeding the transmitter. Head is read combinationally so
// the FSM can load the shift register on the same edge it pops.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  // Fullness/emptiness are pre-edge values, so a push into a full FIFO is
  // dropped even when a pop happens on the same edge.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rptr];

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Store-path UART transmitter: FIFO-buffered bytes serialised as 8N1 frames.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_wr,
  input  logic [7:0]                    uart_wdata,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state, state_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic          tx_q, tx_n;
  logic          pop;
  logic          bit_done;
  logic [7:0]    head;
  logic          fifo_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (uart_wr),
    .pop   (pop),
    .wdata (uart_wdata),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bit_done = (baud_cnt == BAUD_LAST);
  assign tx       = tx_q;
  assign tx_busy  = (state != IDLE) | (fifo_count != '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Datapath registers; tx is registered so no input reaches the pin combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      shift    <= shift_n;
      tx_q     <= tx_n;
    end
  end

  // Next-state and next line value. tx_n is the level for the cycle that
  // starts at the coming edge, so each branch looks one bit ahead.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt + 1'b1;
    bit_n   = bit_idx;
    shift_n = shift;
    tx_n    = tx_q;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        tx_n   = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = head;
          bit_n   = '0;
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (bit_done) begin
          baud_n  = '0;
          state_n = DATA;
          tx_n    = shift[0];
        end
      end
      DATA: begin
        tx_n = shift[0];
        if (bit_done) begin
          baud_n  = '0;
          shift_n = shift >> 1;
          bit_n   = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            tx_n = shift[1];
          end
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (bit_done) begin
          baud_n = '0;
          // Chain straight into the next frame when more data is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = head;
            bit_n   = '0;
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        baud_n  = '0;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule
